fsm_sequencer: RTL and testbench
================================

FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 Parameter OUT_W, default 8: width of led_out.
REQ-002 Parameter CNT_W, default 8: width of count_len, wait_len and the internal step counters.
REQ-003 Parameter PRESCALE, default 10_000_000: clock cycles per tick; legal range 1..2^24-1.
REQ-004 Parameter PAT_IDLE/PAT_WAIT/PAT_DONE, defaults 8'd0/8'd5/8'd15: led_out pattern per state, OUT_W bits.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin sequence; honoured in IDLE only
- advance  in  1  operator step; honoured in WAIT and DONE only
- abort  in  1  return to IDLE from any state
- count_len  in  CNT_W  ticks spent in COUNT; sampled on start
- wait_len  in  CNT_W  ticks spent in WAIT; sampled on start
- led_out  out  OUT_W  registered display value
- state  out  2  current state encoding
- busy  out  1  high in every state except IDLE
- done_pulse  out  1  one-cycle strobe on entry to DONE

Function
REQ-007 States SHALL be IDLE=0, COUNT=1, WAIT=2, DONE=3, registered, with no other reachable encodings.
REQ-008 tick SHALL assert for one cycle when the prescaler equals PRESCALE-1; the prescaler then wraps to 0; PRESCALE=1 gives tick every cycle.
REQ-009 The prescaler SHALL be held at 0 in IDLE, so the first tick comes PRESCALE cycles after leaving IDLE.
REQ-010 IDLE SHALL go to COUNT on the edge where start=1, latch count_len/wait_len, and clear the step counter.
REQ-011 COUNT SHALL increment the step counter on each tick, and go to WAIT on the tick where step counter == len_q-1; count_len=0 SHALL behave as 1.
REQ-012 COUNT residency SHALL be exactly max(len_q,1)*PRESCALE cycles.
REQ-013 WAIT SHALL clear the step counter on entry, then count ticks, and go to DONE after wait_len*PRESCALE cycles or on advance=1, whichever is first; wait_len=0 SHALL wait for advance only.
REQ-014 DONE SHALL hold until advance=1, then go to IDLE.
REQ-015 abort=1 SHALL force IDLE on the next edge from any state, with priority over start, advance and tick expiry.
REQ-016 If advance and WAIT expiry occur in the same cycle, the block SHALL enter DONE once with a single done_pulse.
REQ-017 start outside IDLE and advance in IDLE/COUNT SHALL be ignored with no side effects.
REQ-018 led_out SHALL be registered and update on the same edge as state:
- PAT_IDLE in IDLE
- step counter zero-extended or truncated to OUT_W in COUNT
- PAT_WAIT in WAIT
- PAT_DONE in DONE
REQ-019 done_pulse SHALL be high for exactly the first cycle in DONE; busy = (state != IDLE).
REQ-020 All counters SHALL wrap modulo their width with no overflow flag; the step counter can never exceed len_q-1.

Reset
REQ-021 On reset=1 at an edge, the block SHALL set state=IDLE, led_out=PAT_IDLE, busy=0, done_pulse=0, and clear the prescaler, step counter and latched lengths.
REQ-022 Reset SHALL win over every input, including mid-sequence, and the block SHALL accept start on the first edge after reset deasserts.

Structure
REQ-023 Package fsm_seq_pkg SHALL hold the state encoding constants and default pattern constants.
REQ-024 The prescaler SHALL be a sub-module fsm_tick_gen (clk, reset, run, tick), parametrised by PRESCALE.

Verification (PRESCALE=2, OUT_W=8, CNT_W=8, defaults otherwise)
REQ-025 Nominal run: start with count_len=3, wait_len=2. Required response:
- COUNT for 6 cycles, led_out 0,0,1,1,2,2
- WAIT for 4 cycles, led_out=5
- DONE with a single done_pulse and led_out=15
- advance returns the block to IDLE with led_out=0
REQ-026 Manual wait: wait_len=0. The block SHALL hold WAIT indefinitely; advance in cycle 10 of WAIT SHALL enter DONE on the next edge.
REQ-027 count_len=0 SHALL give COUNT residency of 2 cycles with led_out=0.
REQ-028 Simultaneity: abort asserted together with advance in WAIT SHALL give IDLE, no done_pulse; advance on the WAIT expiry cycle SHALL give exactly one done_pulse.
REQ-029 reset asserted mid-COUNT at step 1 SHALL give all outputs at reset values next cycle; start on the following edge SHALL resume normally.
REQ-030 Ignored inputs: start in WAIT and advance in COUNT SHALL leave state and counters unchanged, including step counter and latched lengths, as checked against a reference model.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: state encoding and default display patterns for the sequencer
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PAT_IDLE_DEF = 8'd0;
    localparam logic [7:0] PAT_WAIT_DEF = 8'd5;
    localparam logic [7:0] PAT_DONE_DEF = 8'd15;

    localparam int PRESCALE_W = 24;

endpackage

// File: rtl/fsm_tick_gen.sv
// fsm_tick_gen: one-cycle tick every PRESCALE cycles while run is high
module fsm_tick_gen
    import fsm_seq_pkg::*;
#(
    parameter int PRESCALE = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = run && (cnt == PRESCALE_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset || !run)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/fsm_sequencer.sv
// fsm_sequencer: IDLE -> COUNT -> WAIT -> DONE sequencer with prescaled timing and led patterns
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int                OUT_W    = 8,
    parameter int                CNT_W    = 8,
    parameter int                PRESCALE = 10_000_000,
    parameter logic [OUT_W-1:0]  PAT_IDLE = OUT_W'(PAT_IDLE_DEF),
    parameter logic [OUT_W-1:0]  PAT_WAIT = OUT_W'(PAT_WAIT_DEF),
    parameter logic [OUT_W-1:0]  PAT_DONE = OUT_W'(PAT_DONE_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic             abort,
    input  logic [CNT_W-1:0] count_len,
    input  logic [CNT_W-1:0] wait_len,
    output logic [OUT_W-1:0] led_out,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done_pulse
);

    state_t           st;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] count_last_step;
    logic             tick;
    logic             count_last;
    logic             wait_last;

    fsm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (st != IDLE),
        .tick  (tick)
    );

    // a zero count length behaves as one tick
    assign count_last_step = (count_q == '0) ? '0 : count_q - 1'b1;
    assign count_last      = step == count_last_step;
    assign wait_last       = (wait_q != '0) && (step == wait_q - 1'b1);
    assign state           = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            step       <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            led_out    <= PAT_IDLE;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (abort) begin
                st      <= IDLE;
                step    <= '0;
                led_out <= PAT_IDLE;
                busy    <= 1'b0;
            end else begin
                case (st)
                    IDLE: if (start) begin
                        st      <= COUNT;
                        count_q <= count_len;
                        wait_q  <= wait_len;
                        step    <= '0;
                        led_out <= '0;
                        busy    <= 1'b1;
                    end
                    COUNT: if (tick) begin
                        if (count_last) begin
                            st      <= WAIT;
                            step    <= '0;
                            led_out <= PAT_WAIT;
                        end else begin
                            step    <= step + 1'b1;
                            led_out <= OUT_W'(step + 1'b1);
                        end
                    end
                    WAIT: begin
                        // advance and expiry together still produce a single entry into DONE
                        if (advance || (tick && wait_last)) begin
                            st         <= DONE;
                            led_out    <= PAT_DONE;
                            done_pulse <= 1'b1;
                        end else if (tick && wait_q != '0) begin
                            step <= step + 1'b1;
                        end
                    end
                    DONE: if (advance) begin
                        st      <= IDLE;
                        led_out <= PAT_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsm_sequencer.sv
// tb_fsm_sequencer: directed scoreboard bench for fsm_sequencer at PRESCALE=2
module tb_fsm_sequencer;
    import fsm_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       advance = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] count_len = '0;
    logic [7:0] wait_len = '0;
    logic [7:0] led_out;
    logic [1:0] state;
    logic       busy;
    logic       done_pulse;

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;

    fsm_sequencer #(.OUT_W(8), .CNT_W(8), .PRESCALE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .advance    (advance),
        .abort      (abort),
        .count_len  (count_len),
        .wait_len   (wait_len),
        .led_out    (led_out),
        .state      (state),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs, queue the expected post-edge outputs, then compare
    task automatic cyc(input logic s, input logic adv, input logic ab,
                       input logic [1:0] es, input logic [7:0] el, input logic ed,
                       input string tag);
        exp_t e;
        logic [11:0] obs;
        start   = s;
        advance = adv;
        abort   = ab;
        exp_q.push_back('{{es, el, es != 2'd0, ed}, tag});
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        obs = {state, led_out, busy, done_pulse};
        checks++;
        assert (obs === e.v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
        start   = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
    endtask

    // nominal count_len=3 wait_len=2 run; noise injects ignored start/advance
    task automatic run_nominal(input logic n, input string tag);
        count_len = 8'd3;
        wait_len  = 8'd2;
        for (int i = 0; i < 6; i++)
            cyc(i == 0, (i > 0) && n, 1'b0, COUNT, 8'(i / 2), 1'b0, {tag, "_count"});
        cyc(1'b0, n, 1'b0, WAIT, 8'd5, 1'b0, {tag, "_wait0"});
        if (n) begin
            count_len = 8'd7;
            wait_len  = 8'd7;
        end
        for (int i = 0; i < 3; i++)
            cyc(n, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, {tag, "_wait"});
        cyc(n, 1'b0, 1'b0, DONE, 8'd15, 1'b1, {tag, "_done_entry"});
        cyc(n, 1'b0, 1'b0, DONE, 8'd15, 1'b0, {tag, "_done_hold"});
        cyc(1'b0, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, {tag, "_to_idle"});
    endtask

    initial begin
        cyc(1'b1, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, "reset0");
        cyc(1'b0, 1'b0, 1'b0, IDLE, 8'd0, 1'b0, "reset1");
        reset = 1'b0;

        run_nominal(1'b0, "nominal");
        run_nominal(1'b1, "ignored");

        count_len = 8'd1;
        wait_len  = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "manual_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "manual_count");
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "manual_wait");
        cyc(1'b0, 1'b1, 1'b0, DONE, 8'd15, 1'b1, "manual_done");
        cyc(1'b0, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, "manual_idle");

        count_len = 8'd0;
        wait_len  = 8'd1;
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "zero_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "zero_count");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "zero_wait");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "zero_wait");
        cyc(1'b0, 1'b0, 1'b0, DONE, 8'd15, 1'b1, "zero_done");
        cyc(1'b0, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, "zero_idle");

        count_len = 8'd1;
        wait_len  = 8'd3;
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "abort_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "abort_count");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "abort_wait");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "abort_wait");
        cyc(1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0, "abort_adv");
        cyc(1'b0, 1'b0, 1'b0, IDLE, 8'd0, 1'b0, "abort_no_pulse");
        cyc(1'b1, 1'b0, 1'b1, IDLE, 8'd0, 1'b0, "abort_over_start");
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "abort_restart");
        cyc(1'b1, 1'b0, 1'b1, IDLE, 8'd0, 1'b0, "abort_in_count");

        wait_len = 8'd1;
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "simul_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "simul_count");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "simul_wait");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "simul_wait");
        cyc(1'b0, 1'b1, 1'b0, DONE, 8'd15, 1'b1, "simul_done");
        cyc(1'b0, 1'b0, 1'b0, DONE, 8'd15, 1'b0, "simul_single");
        cyc(1'b0, 1'b0, 1'b1, IDLE, 8'd0, 1'b0, "abort_in_done");

        count_len = 8'd3;
        wait_len  = 8'd2;
        cyc(1'b1, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "rst_mid_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd0, 1'b0, "rst_mid_count");
        cyc(1'b0, 1'b0, 1'b0, COUNT, 8'd1, 1'b0, "rst_mid_step1");
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, "rst_mid_reset");
        reset = 1'b0;
        count_len = 8'd2;
        wait_len  = 8'd1;
        for (int i = 0; i < 4; i++)
            cyc(i == 0, 1'b0, 1'b0, COUNT, 8'(i / 2), 1'b0, "rst_resume_count");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "rst_resume_wait");
        cyc(1'b0, 1'b0, 1'b0, WAIT, 8'd5, 1'b0, "rst_resume_wait");
        cyc(1'b0, 1'b0, 1'b0, DONE, 8'd15, 1'b1, "rst_resume_done");
        cyc(1'b0, 1'b1, 1'b0, IDLE, 8'd0, 1'b0, "rst_resume_idle");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
